// File: rtl/obsidian_decode_stage.sv
// rtl/obsidian_decode_stage.sv - LEGv8 decode stage: IF_ID decode, 32x64 register file, ID_EX register.
// Optional write-before-read forwarding is enabled by defining OBSIDIAN_DECODE_BYPASS_EN.
module obsidian_decode_stage #(
  parameter int XLEN  = 64,
  parameter int PC_W  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PC_W+31:0]         IF_ID,
  input  logic                     if_valid,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  input  logic [XLEN-1:0]          wb_data,
  output logic                     id_valid,
  output logic [PC_W-1:0]          id_pc,
  output logic [XLEN-1:0]          id_rs1_data,
  output logic [XLEN-1:0]          id_rs2_data,
  output logic [XLEN-1:0]          id_imm,
  output logic [4:0]               id_rd,
  output logic [3:0]               id_alu_op,
  output logic [5:0]               id_ctrl,
  output logic                     id_illegal
);

  localparam int              AW  = $clog2(NREGS);
  localparam logic [AW-1:0]   XZR = AW'(NREGS - 1);

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [9:0]  OP_ADDI = 10'h244;
  localparam logic [9:0]  OP_SUBI = 10'h344;
  localparam logic [5:0]  OP_B    = 6'h05;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_ORR    = 4'd3;
  localparam logic [3:0] ALU_PASS_B = 4'd4;

  // id_ctrl = {reg_write, mem_read, mem_write, branch, cbz, alu_src_imm}
  localparam logic [5:0] C_REG_WRITE = 6'b100000;
  localparam logic [5:0] C_MEM_READ  = 6'b010000;
  localparam logic [5:0] C_MEM_WRITE = 6'b001000;
  localparam logic [5:0] C_BRANCH    = 6'b000100;
  localparam logic [5:0] C_CBZ       = 6'b000010;
  localparam logic [5:0] C_ALU_IMM   = 6'b000001;

  logic [31:0]     instr;
  logic [PC_W-1:0] fetch_pc;
  logic [10:0]     op11;

  assign instr    = IF_ID[31:0];
  assign fetch_pc = IF_ID[PC_W+31:32];
  assign op11     = instr[31:21];

  logic [XLEN-1:0] dec_imm;
  logic [3:0]      dec_alu;
  logic [5:0]      dec_ctrl;
  logic            dec_illegal;
  logic            rs2_from_rt;

  always_comb begin
    dec_imm     = '0;
    dec_alu     = ALU_ADD;
    dec_ctrl    = '0;
    dec_illegal = 1'b0;
    rs2_from_rt = 1'b0;
    // An all-zero word is a NOP and keeps every default.
    if (instr != 32'h0) begin
      if (op11 == OP_ADD || op11 == OP_SUB || op11 == OP_AND || op11 == OP_ORR) begin
        dec_ctrl = C_REG_WRITE;
        case (op11)
          OP_SUB:  dec_alu = ALU_SUB;
          OP_AND:  dec_alu = ALU_AND;
          OP_ORR:  dec_alu = ALU_ORR;
          default: dec_alu = ALU_ADD;
        endcase
      end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI) begin
        dec_ctrl = C_REG_WRITE | C_ALU_IMM;
        dec_imm  = {{(XLEN-12){1'b0}}, instr[21:10]};
        dec_alu  = (instr[31:22] == OP_SUBI) ? ALU_SUB : ALU_ADD;
      end else if (op11 == OP_LDUR) begin
        dec_ctrl = C_REG_WRITE | C_MEM_READ | C_ALU_IMM;
        dec_imm  = {{(XLEN-9){instr[20]}}, instr[20:12]};
      end else if (op11 == OP_STUR) begin
        dec_ctrl    = C_MEM_WRITE | C_ALU_IMM;
        dec_imm     = {{(XLEN-9){instr[20]}}, instr[20:12]};
        rs2_from_rt = 1'b1;
      end else if (instr[31:26] == OP_B) begin
        dec_ctrl = C_BRANCH;
        dec_imm  = {{(XLEN-26){instr[25]}}, instr[25:0]};
      end else if (instr[31:24] == OP_CBZ) begin
        dec_ctrl    = C_CBZ;
        dec_imm     = {{(XLEN-19){instr[23]}}, instr[23:5]};
        dec_alu     = ALU_PASS_B;
        rs2_from_rt = 1'b1;
      end else begin
        dec_illegal = 1'b1;
      end
    end
  end

  logic [XLEN-1:0] regs [NREGS];
  logic [AW-1:0]   rs1_idx;
  logic [AW-1:0]   rs2_idx;
  logic            byp1;
  logic            byp2;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  assign rs1_idx = AW'(instr[9:5]);
  assign rs2_idx = rs2_from_rt ? AW'(instr[4:0]) : AW'(instr[20:16]);

`ifdef OBSIDIAN_DECODE_BYPASS_EN
  assign byp1 = wb_en && (wb_addr == rs1_idx) && (wb_addr != XZR);
  assign byp2 = wb_en && (wb_addr == rs2_idx) && (wb_addr != XZR);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign rs1_data = (rs1_idx == XZR) ? '0 : (byp1 ? wb_data : regs[rs1_idx]);
  assign rs2_data = (rs2_idx == XZR) ? '0 : (byp2 ? wb_data : regs[rs2_idx]);

  // Writeback runs independently of stall/flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en && wb_addr != XZR) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid    <= 1'b0;
      id_pc       <= '0;
      id_rs1_data <= '0;
      id_rs2_data <= '0;
      id_imm      <= '0;
      id_rd       <= '0;
      id_alu_op   <= '0;
      id_ctrl     <= '0;
      id_illegal  <= 1'b0;
    end else if (flush) begin
      id_valid   <= 1'b0;
      id_ctrl    <= '0;
      id_illegal <= 1'b0;
    end else if (!stall) begin
      id_valid    <= if_valid;
      id_pc       <= fetch_pc;
      id_rs1_data <= rs1_data;
      id_rs2_data <= rs2_data;
      id_imm      <= dec_imm;
      id_rd       <= instr[4:0];
      id_alu_op   <= dec_alu;
      id_ctrl     <= if_valid ? dec_ctrl : 6'b0;
      id_illegal  <= if_valid & dec_illegal;
    end
  end

endmodule
